// File: rtl/elliptic_curve_structs.sv
// rtl/elliptic_curve_structs.sv - shared field parameters and state types for curve arithmetic
package elliptic_curve_structs;

   // Default prime field: a small field so the datapath stays easy to exercise
   localparam int                 P_WIDTH = 7;
   localparam logic [P_WIDTH-1:0] P       = 7'd101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } mod_inv_state_t;

endpackage

// File: rtl/mod_half_sub.sv
// rtl/mod_half_sub.sv - combinational modular halve and modular subtract-with-wrap for the inverter x registers
module mod_half_sub
   import elliptic_curve_structs::*;
#(
   parameter int                 WIDTH   = P_WIDTH,
   parameter logic [WIDTH-1:0]   MODULUS = P
) (
   input  logic [WIDTH:0] x,
   input  logic [WIDTH:0] y,
   output logic [WIDTH:0] half,
   output logic [WIDTH:0] diff
);

   // x and y stay below MODULUS, so x + MODULUS fits in WIDTH+1 bits
   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] sum;

   assign m_ext = {1'b0, MODULUS};
   assign sum   = x + m_ext;

   // Odd x is made even by adding the (odd) modulus before halving
   assign half = x[0] ? {1'b0, sum[WIDTH:1]} : {1'b0, x[WIDTH:1]};

   // Wrap negative differences back into the field
   assign diff = (x >= y) ? (x - y) : (sum - y);

endmodule

// File: rtl/mod_inverter.sv
// rtl/mod_inverter.sv - modular inverse by binary extended Euclid, one step per clock
module mod_inverter
   import elliptic_curve_structs::*;
#(
   parameter int                 WIDTH   = P_WIDTH,
   parameter logic [WIDTH-1:0]   MODULUS = P
) (
   input  logic             clk,
   input  logic             Reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             invalid
);

   localparam int             CW        = $clog2(4*WIDTH+4);
   localparam logic [CW-1:0]  CNT_LIMIT = CW'(4*WIDTH+2);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   mod_inv_state_t   state_q, state_d;
   logic [WIDTH-1:0] u_q, u_d, v_q, v_d;
   logic [WIDTH:0]   x1_q, x1_d, x2_q, x2_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             busy_d, done_d, invalid_d;
   logic [WIDTH-1:0] result_d;

   logic [WIDTH:0]   x1_half, x1_diff, x2_half, x2_diff;

   mod_half_sub #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_hs_u (
      .x    (x1_q),
      .y    (x2_q),
      .half (x1_half),
      .diff (x1_diff)
   );

   mod_half_sub #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_hs_v (
      .x    (x2_q),
      .y    (x1_q),
      .half (x2_half),
      .diff (x2_diff)
   );

   // Next-state and datapath update: one Euclid step per RUN cycle
   always_comb begin
      state_d   = state_q;
      u_d       = u_q;
      v_d       = v_q;
      x1_d      = x1_q;
      x2_d      = x2_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      busy_d    = busy;
      done_d    = 1'b0;
      result_d  = result;
      invalid_d = invalid;
      case (state_q)
         IDLE: begin
            // A start coinciding with the done pulse is deliberately not taken
            if (start && !done) begin
               u_d     = a;
               v_d     = MODULUS;
               x1_d    = {{WIDTH{1'b0}}, 1'b1};
               x2_d    = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               err_d   = (a == '0);
               state_d = (a == '0) ? FINISH : RUN;
            end
         end
         RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (u_q == ONE || v_q == ONE) begin
               state_d = FINISH;
            end else if (cnt_d == CNT_LIMIT) begin
               // Safety net against a non-terminating loop on illegal operands
               err_d   = 1'b1;
               state_d = FINISH;
            end else if (!u_q[0]) begin
               u_d  = u_q >> 1;
               x1_d = x1_half;
            end else if (!v_q[0]) begin
               v_d  = v_q >> 1;
               x2_d = x2_half;
            end else if (u_q >= v_q) begin
               u_d  = u_q - v_q;
               x1_d = x1_diff;
            end else begin
               v_d  = v_q - u_q;
               x2_d = x2_diff;
            end
         end
         FINISH: begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            invalid_d = err_q;
            if (err_q)
               result_d = '0;
            else
               result_d = (u_q == ONE) ? x1_q[WIDTH-1:0] : x2_q[WIDTH-1:0];
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, cleared immediately on reset so an aborted job never reports
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         u_q     <= '0;
         v_q     <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         invalid <= 1'b0;
      end else begin
         state_q <= state_d;
         u_q     <= u_d;
         v_q     <= v_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         busy    <= busy_d;
         done    <= done_d;
         result  <= result_d;
         invalid <= invalid_d;
      end
   end

   // Operands at or above the modulus have no meaning in the field
   a_operand_in_field: assert property (@(posedge clk) disable iff (!Reset_n)
      (state_q == IDLE && start && !done) |-> (a < MODULUS));

endmodule

// File: tb/tb_mod_inverter.sv
// tb/tb_mod_inverter.sv - self-checking scoreboard bench for mod_inverter over GF(101)
module tb_mod_inverter;

   localparam int         W = 7;
   localparam logic [6:0] M = 7'd101;

   logic         clk = 1'b0;
   logic         Reset_n;
   logic         start;
   logic [W-1:0] a;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         invalid;

   typedef struct packed {
      logic [W-1:0] op;
      logic [W-1:0] res;
      logic         inv;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   mod_inverter #(.WIDTH(W), .MODULUS(M)) dut (
      .clk     (clk),
      .Reset_n (Reset_n),
      .start   (start),
      .a       (a),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .invalid (invalid)
   );

   function automatic logic [W-1:0] model_inv(input int av);
      for (int r = 1; r < 101; r++)
         if ((av * r) % 101 == 1) return W'(r);
      return '0;
   endfunction

   // Drive one start pulse in the cycle after the current one; leaves time at accept edge + 1
   task automatic issue(input int av);
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      a     = W'(av);
      start = 1'b1;
      e.op  = W'(av);
      e.res = model_inv(av);
      e.inv = (av == 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Latency counts clock edges from the accepting edge up to the edge that raises done
   task automatic wait_done(output int lat, output bit ok);
      lat = 1;
      ok  = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      start   = 1'b0;
      a       = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0)    $display("FAIL reset_busy got %b want 0", busy);       else passed++;
      total++; if (done !== 1'b0)    $display("FAIL reset_done got %b want 0", done);       else passed++;
      total++; if (result !== '0)    $display("FAIL reset_result got %0d want 0", result);  else passed++;
      total++; if (invalid !== 1'b0) $display("FAIL reset_invalid got %b want 0", invalid); else passed++;
      @(negedge clk);
      Reset_n = 1'b1;
   endtask

   task automatic test_known();
      int   ops[3] = '{3, 2, 100};
      int   want[3] = '{34, 51, 100};
      int   lat;
      bit   ok;
      exp_t e;
      foreach (ops[i]) begin
         issue(ops[i]);
         wait_done(lat, ok);
         e = sb.pop_front();
         total++;
         if (!ok) begin
            $display("FAIL known_timeout a=%0d no done within 40 cycles", ops[i]);
            continue;
         end
         passed++;
         total++; if (result !== W'(want[i])) $display("FAIL known_result a=%0d got %0d want %0d", ops[i], result, want[i]); else passed++;
         total++; if (result !== e.res)       $display("FAIL known_model a=%0d got %0d want %0d", ops[i], result, e.res); else passed++;
         total++; if (invalid !== 1'b0)       $display("FAIL known_invalid a=%0d got %b want 0", ops[i], invalid); else passed++;
         total++; if (busy !== 1'b0)          $display("FAIL known_busy a=%0d got %b want 0", ops[i], busy); else passed++;
         total++; if (lat > 32)               $display("FAIL known_latency a=%0d got %0d want <=32", ops[i], lat); else passed++;
         @(posedge clk);
         #1;
         total++; if (done !== 1'b0)          $display("FAIL known_pulse a=%0d done still %b want 0", ops[i], done); else passed++;
         total++; if (result !== e.res)       $display("FAIL known_hold a=%0d got %0d want %0d", ops[i], result, e.res); else passed++;
      end
   endtask

   task automatic test_edges();
      int   lat;
      bit   ok;
      exp_t e;
      issue(1);
      wait_done(lat, ok);
      e = sb.pop_front();
      total++; if (!ok)          $display("FAIL one_timeout no done within 40 cycles"); else passed++;
      total++; if (lat !== 3)    $display("FAIL one_latency got %0d want 3", lat); else passed++;
      total++; if (result !== e.res || result !== 7'd1) $display("FAIL one_result got %0d want 1", result); else passed++;
      issue(0);
      wait_done(lat, ok);
      e = sb.pop_front();
      total++; if (!ok)          $display("FAIL zero_timeout no done within 40 cycles"); else passed++;
      total++; if (lat !== 2)    $display("FAIL zero_latency got %0d want 2", lat); else passed++;
      total++; if (invalid !== e.inv) $display("FAIL zero_invalid got %b want %b", invalid, e.inv); else passed++;
      total++; if (result !== '0) $display("FAIL zero_result got %0d want 0", result); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL zero_busy got %b want 0", busy); else passed++;
   endtask

   task automatic test_back_to_back();
      int   lat;
      bit   ok;
      exp_t e;
      for (int i = 1; i <= 100; i++) begin
         issue(i);
         wait_done(lat, ok);
         e = sb.pop_front();
         total++;
         if (!ok) begin
            $display("FAIL sweep_timeout a=%0d no done within 40 cycles", i);
            continue;
         end
         passed++;
         total++; if ((i * int'(result)) % 101 != 1) $display("FAIL sweep_product a=%0d got result %0d want a*result mod 101 == 1", i, result); else passed++;
         total++; if (result !== e.res || invalid !== 1'b0) $display("FAIL sweep_model a=%0d got %0d/%b want %0d/0", i, result, invalid, e.res); else passed++;
         total++; if (lat > 32) $display("FAIL sweep_latency a=%0d got %0d want <=32", i, lat); else passed++;
      end
   endtask

   task automatic test_busy_ignore();
      int   lat;
      bit   ok;
      bit   extra;
      exp_t e;
      issue(5);
      @(negedge clk);
      a     = 7'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, ok);
      e = sb.pop_front();
      total++; if (!ok) $display("FAIL busy_timeout no done within 40 cycles"); else passed++;
      total++; if (result !== e.res || result !== 7'd81) $display("FAIL busy_result got %0d want 81", result); else passed++;
      // start raised in the done cycle itself must be ignored
      @(negedge clk);
      a     = 7'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      total++; if (busy !== 1'b0) $display("FAIL done_cycle_start busy got %b want 0", busy); else passed++;
      extra = 1'b0;
      repeat (40) begin
         if (done) extra = 1'b1;
         @(posedge clk);
         #1;
      end
      total++; if (extra) $display("FAIL busy_extra_done got a second done want none"); else passed++;
      total++; if (sb.size() != 0) $display("FAIL busy_scoreboard got %0d pending want 0", sb.size()); else passed++;
   endtask

   task automatic test_reset_mid();
      int   lat;
      bit   ok;
      bit   extra;
      exp_t e;
      issue(3);
      repeat (2) @(posedge clk);
      #1;
      total++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", busy); else passed++;
      @(negedge clk);
      Reset_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0)   $display("FAIL mid_reset_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0)   $display("FAIL mid_reset_done got %b want 0", done); else passed++;
      total++; if (result !== '0)   $display("FAIL mid_reset_result got %0d want 0", result); else passed++;
      void'(sb.pop_front());
      @(negedge clk);
      Reset_n = 1'b1;
      extra = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) extra = 1'b1;
      end
      total++; if (extra) $display("FAIL mid_reset_done_after got a done want none"); else passed++;
      issue(3);
      wait_done(lat, ok);
      e = sb.pop_front();
      total++; if (!ok) $display("FAIL after_reset_timeout no done within 40 cycles"); else passed++;
      total++; if (result !== e.res || result !== 7'd34) $display("FAIL after_reset_result got %0d want 34", result); else passed++;
   endtask

   initial begin
      test_reset();
      test_known();
      test_edges();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mod_inverter.md
Name: mod_inverter

Overview:
- Computes the modular inverse result = a^-1 mod MODULUS using the binary extended Euclidean algorithm, one step per clock.
- It is the counterpart to the field multiplier. Point-addition and point-doubling datapaths use it to replace division, then multiply the result back.
- It uses the same start/done style as the multiplier adapter, so the curve-arithmetic sequencer drives both the same way.

Parameters:
- WIDTH, default P_WIDTH (from elliptic_curve_structs), operand/result bit width.
- MODULUS, default P (from elliptic_curve_structs), odd prime field modulus, MODULUS < 2^WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand; must satisfy a < MODULUS; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until the done pulse.
- done  out  1  one-cycle pulse; result and invalid are valid in that cycle and held afterwards.
- result  out  WIDTH  inverse of a, in the range 1..MODULUS-1.
- invalid  out  1  set when a == 0 (no inverse exists); result is 0 in that case.

Behaviour:
- Reset (asynchronous, Reset_n low): state=IDLE, busy=0, done=0, result=0, invalid=0, all internal registers cleared.
- Internal registers:
  - u, v: WIDTH bits.
  - x1, x2: WIDTH+1 bits, so that x+MODULUS cannot overflow.
  - cycle counter: clog2(4*WIDTH+4) bits.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - If start=1, load u=a, v=MODULUS, x1=1, x2=0, clear the counter, and go to RUN.
  - If start=1 and a==0, go to FINISH with invalid=1 instead.
- RUN: exactly one action per cycle, in this priority order:
  1. If u==1 or v==1: go to FINISH.
  2. Else if u is even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+MODULUS)>>1.
  3. Else if v is even: the same operation on v and x2.
  4. Else if u>=v: u=u-v; x1 = x1>=x2 ? x1-x2 : x1+MODULUS-x2.
  5. Else: v=v-u; x2 = x2>=x1 ? x2-x1 : x2+MODULUS-x1.
- Counter: increments every RUN cycle. If it reaches 4*WIDTH+2, go to FINISH with invalid=1. This is a safety net and is unreachable for legal inputs.
- FINISH:
  - Register result = (u==1) ? x1 : x2, truncated to WIDTH bits (already < MODULUS). If invalid, result=0.
  - Pulse done=1 for one cycle, drop busy in the same cycle, and return to IDLE.
- Latency:
  - Accepted start to done is at most 4*WIDTH+4 cycles.
  - a==0 gives done on cycle 2 (IDLE to FINISH to done).
  - a==1 gives done on cycle 3: in its single RUN cycle u==1 is detected, then FINISH.
- Boundary conditions:
  - start while busy: ignored; a is not re-sampled.
  - start in the same cycle as the done pulse: ignored. The earliest new accept is the cycle after done.
  - Reset_n asserted mid-operation: immediate return to IDLE with outputs cleared; no done pulse is produced for the aborted job.
  - a >= MODULUS: illegal input; the bench must not drive it. The RTL carries an assertion for it.

Decomposition:
- P, P_WIDTH and a mod_inv_state_t enum {IDLE, RUN, FINISH} belong in elliptic_curve_structs.
- One natural sub-module: mod_half_sub. It is combinational and implements the modular halve and modular subtract-with-wrap for the x registers. The RUN step instantiates it twice, once for the u/x1 path and once for the v/x2 path.

Test Plan:
- MODULUS=101, WIDTH=7; a=3, start=1 for one cycle -> one done pulse within 32 cycles with result=34, invalid=0, busy low after done.
- Same configuration; a=2 -> result=51. a=100 -> result=100. a=1 -> result=1 with done exactly 3 cycles after the accept.
- a=0 -> done 2 cycles after the accept, invalid=1, result=0.
- Exhaustive sweep, a=1..100 back-to-back with start raised the cycle after each done -> (a*result) mod 101 == 1 every time and latency <= 32 every time.
- Start pulsed at a=5, then start pulsed again with a=7 while busy -> a single done with result=81 (5*81=405=4*101+1); the second request is dropped.
- Reset_n pulsed low mid-RUN -> busy=0, done=0, result=0 immediately and no done pulse afterwards. A subsequent start with a=3 -> result=34.
